multdiv_ctrl: RTL and testbench
===============================

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have these ports, in order: clk, reset, then the remaining ports listed below.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces every register to its reset value immediately.
REQ-004 dx_valid  in  1  the D/X latch holds a live instruction.
REQ-005 dx_opcode  in  5  D/X instruction opcode.
REQ-006 dx_aluop  in  5  D/X ALU opcode field; 00110 = mul, 00111 = div.
REQ-007 dx_rd  in  5  D/X destination register.
REQ-008 dx_A, dx_B  in  32 each  D/X operands after bypassing.
REQ-009 md_result  in  32  data_result from the ALU/multdiv wrapper.
REQ-010 md_exception  in  1  data_exception from the wrapper.
REQ-011 md_ready  in  1  data_resultRDY from the wrapper.
REQ-012 op_A, op_B  out  32 each  operands driven into the wrapper.
REQ-013 op_aluop  out  5  ALU opcode driven into the wrapper.
REQ-014 multDivPrev  out  1  driven to the wrapper; 1 = an operation is in flight.
REQ-015 stall  out  1  freezes PC, F/D and D/X.
REQ-016 wb_valid  out  1  one-cycle pulse: write wb_data to wb_rd.
REQ-017 wb_rd  out  5  registered destination register.
REQ-018 wb_data  out  32  registered result data.
REQ-019 timeout  out  1  sticky error flag.

Function
REQ-020 The state machine SHALL have three states: IDLE, BUSY and DONE; the reset state is IDLE.
REQ-021 A launch is defined as IDLE && dx_valid && dx_opcode==00000 && dx_aluop in {00110, 00111}.
REQ-022 In IDLE, op_A, op_B and op_aluop SHALL pass through dx_A, dx_B and dx_aluop combinationally, and multDivPrev SHALL be 0.
REQ-023 On a launch, stall SHALL be 1 combinationally in that same cycle.
REQ-024 On the launch edge, the block SHALL latch A, B, aluop and rd, clear the 6-bit cycle counter, and enter BUSY.
REQ-025 In BUSY, op_A, op_B and op_aluop SHALL come from the latched values, multDivPrev SHALL be 1, stall SHALL be 1, and the counter SHALL increment each cycle, saturating at 63.
REQ-026 BUSY with md_ready=1 SHALL enter DONE and register the write-back: wb_data=md_result and wb_rd=latched rd.
REQ-027 If md_exception=1 at capture, the block SHALL instead register wb_rd=30 and wb_data=4 for mul or 5 for div.
REQ-028 In DONE, wb_valid SHALL be 1 for exactly one cycle, stall SHALL be 0 and multDivPrev SHALL be 0; the next edge SHALL return the machine to IDLE.
REQ-029 If wb_rd==0 and there is no exception, wb_valid SHALL stay 0 in DONE (r0 write suppressed).
REQ-030 BUSY with counter==63 and md_ready=0 SHALL set timeout, register wb_rd=30 and wb_data per REQ-027, and enter DONE.
REQ-031 If md_ready=1 and counter==63 occur in the same cycle, md_ready SHALL win and timeout SHALL stay unchanged.
REQ-032 Changes on the dx_* inputs during BUSY or DONE SHALL be ignored, and no launch SHALL be accepted in DONE.
REQ-033 A back-to-back mul/div presented in the IDLE cycle after DONE SHALL launch normally, giving a minimum of 1 IDLE cycle between operations.
REQ-034 dx_valid=0, or any non-mul/div instruction, SHALL produce stall=0 and no state change.
REQ-035 Total stall length SHALL be the wrapper latency plus 1 cycles.

Reset
REQ-036 reset SHALL asynchronously force: state=IDLE, counter=0, latched A/B/aluop/rd=0, stall=0, multDivPrev=0, wb_valid=0, wb_rd=0, wb_data=0 and timeout=0.
REQ-037 A reset during BUSY SHALL abandon the operation with no wb_valid pulse, and the first edge after release SHALL be able to launch.
REQ-038 timeout SHALL be cleared only by reset.

Verification
REQ-039 Mul test: launch mul with A=7, B=-3, rd=5; md_ready after 17 cycles with md_result=-21 -> stall high for 18 cycles, then wb_valid=1, wb_rd=5, wb_data=0xFFFFFFEB.
REQ-040 Div-by-zero test: launch div with A=10, B=0, rd=4; md_ready with md_exception=1 -> wb_rd=30, wb_data=5, timeout=0.
REQ-041 Hold test: during BUSY, drive dx_A=0xDEADBEEF -> op_A remains the launch value, and multDivPrev=1 for every BUSY cycle.
REQ-042 Timeout test: md_ready never asserted -> at counter 63: timeout=1, wb_rd=30, then IDLE; timeout stays 1 until reset.
REQ-043 Reset test: assert reset mid-BUSY (asynchronously, between edges) -> all outputs 0 immediately, no write-back; a mul launched after release completes correctly.
REQ-044 Back-to-back test: back-to-back mul then div, plus a mul with rd=0 -> two write-backs in order, exactly one IDLE cycle between, and no wb_valid for the rd=0 operation.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Pipeline-side controller for the multi-cycle multiplier/divider: launches an
// operation from D/X, holds operands while it runs, and registers the write-back.
module multdiv_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        dx_valid,
    input  logic [4:0]  dx_opcode,
    input  logic [4:0]  dx_aluop,
    input  logic [4:0]  dx_rd,
    input  logic [31:0] dx_A,
    input  logic [31:0] dx_B,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic [31:0] op_A,
    output logic [31:0] op_B,
    output logic [4:0]  op_aluop,
    output logic        multDivPrev,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;
    localparam logic [4:0] RD_EXC  = 5'd30;
    localparam logic [5:0] CNT_MAX = 6'd63;

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] lat_a;
    logic [31:0] lat_b;
    logic [4:0]  lat_aluop;
    logic [4:0]  lat_rd;
    logic        launch;
    logic [31:0] exc_code;

    assign launch = (state == IDLE) && dx_valid && (dx_opcode == 5'b00000) &&
                    ((dx_aluop == ALU_MUL) || (dx_aluop == ALU_DIV));

    assign exc_code = (lat_aluop == ALU_DIV) ? 32'd5 : 32'd4;

    // Operands pass straight through until an operation owns the wrapper.
    always_comb begin
        op_A        = dx_A;
        op_B        = dx_B;
        op_aluop    = dx_aluop;
        multDivPrev = 1'b0;
        stall       = 1'b0;
        if (state != IDLE) begin
            op_A     = lat_a;
            op_B     = lat_b;
            op_aluop = lat_aluop;
        end
        if (state == BUSY) begin
            multDivPrev = 1'b1;
        end
        if (!reset && (launch || state == BUSY)) begin
            stall = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            lat_a     <= 32'd0;
            lat_b     <= 32'd0;
            lat_aluop <= 5'd0;
            lat_rd    <= 5'd0;
            wb_valid  <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= 32'd0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        lat_a     <= dx_A;
                        lat_b     <= dx_B;
                        lat_aluop <= dx_aluop;
                        lat_rd    <= dx_rd;
                        cnt       <= 6'd0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 6'd1;
                    end
                    // A result arriving on the last allowed cycle still wins over the timeout.
                    if (md_ready) begin
                        state <= DONE;
                        if (md_exception) begin
                            wb_rd    <= RD_EXC;
                            wb_data  <= exc_code;
                            wb_valid <= 1'b1;
                        end else begin
                            wb_rd    <= lat_rd;
                            wb_data  <= md_result;
                            wb_valid <= (lat_rd != 5'd0);
                        end
                    end else if (cnt == CNT_MAX) begin
                        timeout  <= 1'b1;
                        wb_rd    <= RD_EXC;
                        wb_data  <= exc_code;
                        wb_valid <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    wb_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: mul/div write-back, exceptions, timeout,
// operand hold, async reset and back-to-back launches.
module tb_multdiv_ctrl;

    localparam logic [4:0] MUL = 5'b00110;
    localparam logic [4:0] DIV = 5'b00111;

    logic        clk = 1'b0;
    logic        reset;
    logic        dx_valid;
    logic [4:0]  dx_opcode;
    logic [4:0]  dx_aluop;
    logic [4:0]  dx_rd;
    logic [31:0] dx_A;
    logic [31:0] dx_B;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;
    logic [31:0] op_A;
    logic [31:0] op_B;
    logic [4:0]  op_aluop;
    logic        multDivPrev;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;

    multdiv_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .dx_valid     (dx_valid),
        .dx_opcode    (dx_opcode),
        .dx_aluop     (dx_aluop),
        .dx_rd        (dx_rd),
        .dx_A         (dx_A),
        .dx_B         (dx_B),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_ready     (md_ready),
        .op_A         (op_A),
        .op_B         (op_B),
        .op_aluop     (op_aluop),
        .multDivPrev  (multDivPrev),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full operation from launch to DONE; lat==0 means the wrapper never answers.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] aluop, input logic [4:0] rd, input int lat,
                          input logic [31:0] res, input logic exc, input logic exp_v,
                          input logic [4:0] exp_rd, input logic [31:0] exp_data,
                          input logic exp_to, input int exp_stall);
        int  n;
        int  stall_cnt;
        bit  prev_ok;
        bit  hold_ok;
        n         = (lat == 0) ? 64 : lat;
        stall_cnt = 0;
        prev_ok   = 1'b1;
        hold_ok   = 1'b1;
        @(posedge clk); #1;
        dx_valid  = 1'b1;
        dx_opcode = 5'd0;
        dx_aluop  = aluop;
        dx_rd     = rd;
        dx_A      = a;
        dx_B      = b;
        @(negedge clk);
        check_eq({tag, "_launch_stall"}, {31'd0, stall}, 32'd1);
        check_eq({tag, "_launch_wbv"}, {31'd0, wb_valid}, 32'd0);
        if (stall) stall_cnt++;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            dx_A         = 32'hDEADBEEF;
            dx_aluop     = 5'b00010;
            dx_rd        = 5'd31;
            md_ready     = (lat != 0) && (k == lat);
            md_exception = exc && (k == lat);
            md_result    = res;
            @(negedge clk);
            if (stall) stall_cnt++;
            if (multDivPrev !== 1'b1) prev_ok = 1'b0;
            if (op_A !== a || op_B !== b || op_aluop !== aluop) hold_ok = 1'b0;
        end
        @(posedge clk); #1;
        md_ready     = 1'b0;
        md_exception = 1'b0;
        dx_A         = a;
        dx_aluop     = aluop;
        @(negedge clk);
        check_eq({tag, "_busy_prev"}, {31'd0, prev_ok}, 32'd1);
        check_eq({tag, "_busy_hold"}, {31'd0, hold_ok}, 32'd1);
        check_eq({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
        check_eq({tag, "_done_prev"}, {31'd0, multDivPrev}, 32'd0);
        check_eq({tag, "_wb_valid"}, {31'd0, wb_valid}, {31'd0, exp_v});
        check_eq({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, exp_rd});
        check_eq({tag, "_wb_data"}, wb_data, exp_data);
        check_eq({tag, "_timeout"}, {31'd0, timeout}, {31'd0, exp_to});
        check_eq({tag, "_stall_len"}, stall_cnt, exp_stall);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        dx_valid = 1'b0;
        @(negedge clk);
        check_eq("idle_wbv", {31'd0, wb_valid}, 32'd0);
    endtask

    task automatic no_launch(input string tag, input logic v, input logic [4:0] opc,
                             input logic [4:0] aluop);
        @(posedge clk); #1;
        dx_valid  = v;
        dx_opcode = opc;
        dx_aluop  = aluop;
        dx_A      = 32'h0000_0123;
        @(negedge clk);
        check_eq({tag, "_stall"}, {31'd0, stall}, 32'd0);
        check_eq({tag, "_opA"}, op_A, 32'h0000_0123);
        @(posedge clk); #1;
        dx_valid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_prev"}, {31'd0, multDivPrev}, 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        dx_valid     = 1'b0;
        dx_opcode    = 5'd0;
        dx_aluop     = 5'd0;
        dx_rd        = 5'd0;
        dx_A         = 32'd0;
        dx_B         = 32'd0;
        md_result    = 32'd0;
        md_exception = 1'b0;
        md_ready     = 1'b0;
        #23;
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_prev", {31'd0, multDivPrev}, 32'd0);
        check_eq("rst_wbv", {31'd0, wb_valid}, 32'd0);
        check_eq("rst_wbrd", {27'd0, wb_rd}, 32'd0);
        check_eq("rst_wbdata", wb_data, 32'd0);
        check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
        reset = 1'b0;

        no_launch("alu_add", 1'b1, 5'd0, 5'b00000);
        no_launch("bad_opc", 1'b1, 5'd3, MUL);
        no_launch("not_valid", 1'b0, 5'd0, MUL);

        // mul, then div and an r0 mul back-to-back
        run_op("mul", 32'd7, 32'hFFFF_FFFD, MUL, 5'd5, 17, 32'hFFFF_FFEB, 1'b0,
               1'b1, 5'd5, 32'hFFFF_FFEB, 1'b0, 18);
        run_op("b2b_div", 32'd100, 32'd7, DIV, 5'd9, 3, 32'd14, 1'b0,
               1'b1, 5'd9, 32'd14, 1'b0, 4);
        run_op("mul_r0", 32'd3, 32'd4, MUL, 5'd0, 2, 32'd12, 1'b0,
               1'b0, 5'd0, 32'd12, 1'b0, 3);
        idle_cycle();

        run_op("div0", 32'd10, 32'd0, DIV, 5'd4, 5, 32'd0, 1'b1,
               1'b1, 5'd30, 32'd5, 1'b0, 6);
        run_op("mul_exc", 32'd1, 32'd2, MUL, 5'd8, 1, 32'd0, 1'b1,
               1'b1, 5'd30, 32'd4, 1'b0, 2);
        run_op("ready_at_63", 32'd2, 32'd3, MUL, 5'd12, 64, 32'd6, 1'b0,
               1'b1, 5'd12, 32'd6, 1'b0, 65);
        run_op("tmo", 32'd9, 32'd9, MUL, 5'd7, 0, 32'd0, 1'b0,
               1'b1, 5'd30, 32'd4, 1'b1, 65);
        idle_cycle();
        idle_cycle();
        check_eq("tmo_sticky_idle", {31'd0, timeout}, 32'd1);
        run_op("after_tmo", 32'd5, 32'd5, MUL, 5'd2, 4, 32'd25, 1'b0,
               1'b1, 5'd2, 32'd25, 1'b1, 5);

        // async reset in the middle of an operation
        @(posedge clk); #1;
        dx_valid = 1'b1; dx_opcode = 5'd0; dx_aluop = MUL; dx_rd = 5'd3;
        dx_A = 32'd11; dx_B = 32'd2;
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_stall", {31'd0, stall}, 32'd0);
        check_eq("mid_rst_prev", {31'd0, multDivPrev}, 32'd0);
        check_eq("mid_rst_wbv", {31'd0, wb_valid}, 32'd0);
        check_eq("mid_rst_wbrd", {27'd0, wb_rd}, 32'd0);
        check_eq("mid_rst_wbdata", wb_data, 32'd0);
        check_eq("mid_rst_timeout", {31'd0, timeout}, 32'd0);
        @(negedge clk);
        dx_A = 32'd6; dx_B = 32'd7; dx_rd = 5'd6;
        #2;
        reset = 1'b0;
        check_eq("rel_wbv", {31'd0, wb_valid}, 32'd0);
        @(posedge clk); #1;
        check_eq("rel_launch_prev", {31'd0, multDivPrev}, 32'd1);
        check_eq("rel_launch_opA", op_A, 32'd6);
        md_ready = 1'b1; md_result = 32'd42;
        @(posedge clk); #1;
        md_ready = 1'b0; dx_valid = 1'b0;
        check_eq("rel_wbv_done", {31'd0, wb_valid}, 32'd1);
        check_eq("rel_wbrd", {27'd0, wb_rd}, 32'd6);
        check_eq("rel_wbdata", wb_data, 32'd42);
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
